// File: rtl/lif_tdm_sched.sv
// Time-multiplexed LIF scheduler: one leak/integrate/fire datapath shared by N_NEURONS neurons; optional LIF_SPIKE_COUNT_EN adds spike counters.
// Latency: tick accepted at edge 0, spike_out/step_done valid after edge N_NEURONS+1; minimum tick spacing N_NEURONS+2.
// Backpressure: none; ticks and cfg writes while busy are dropped and flagged in sticky tick_overrun / cfg_err.
module lif_tdm_sched #(
    parameter int N_NEURONS  = 4,
    parameter int V_WIDTH    = 8,
    parameter int THRESH_RST = 200,
    parameter int WEIGHT_RST = 40,
    parameter int LEAK_RST   = 3,
    parameter int REFRAC_RST = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         tick,
    input  logic [N_NEURONS-1:0]         spike_in,
    input  logic                         cfg_we,
    input  logic [1:0]                   cfg_addr,
    input  logic [7:0]                   cfg_data,
    input  logic                         ovr_clr,
    output logic [N_NEURONS-1:0]         spike_out,
    output logic                         step_done,
    output logic                         busy,
    output logic                         tick_overrun,
    output logic                         cfg_err,
    input  logic [$clog2(N_NEURONS)-1:0] rd_sel,
    output logic [7:0]                   rd_data
);
    localparam int IW = $clog2(N_NEURONS);

    typedef enum logic [1:0] {IDLE, UPDATE, DONE} state_t;

    typedef struct packed {
        logic [7:0] thresh;
        logic [7:0] weight;
        logic [2:0] leak;
        logic [3:0] refrac;
    } cfg_t;

    localparam cfg_t CFG_RST = '{thresh: 8'(THRESH_RST), weight: 8'(WEIGHT_RST),
                                 leak: 3'(LEAK_RST), refrac: 4'(REFRAC_RST)};

    state_t               state, state_nxt;
    cfg_t                 cfg;
    logic [IW-1:0]        idx;
    logic [N_NEURONS-1:0] in_q;
    logic [N_NEURONS-1:0] acc;
    logic [V_WIDTH-1:0]   v_mem [N_NEURONS];
    logic [3:0]           r_mem [N_NEURONS];

    logic               in_idle, start, cfg_wr, last;
    logic [V_WIDTH-1:0] v_cur, leak_amt, v_leak, sum_sat;
    logic [V_WIDTH:0]   sum_w;
    logic [3:0]         r_cur;
    logic               refractory, fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_idle   = (state == IDLE);
        start     = in_idle && tick;
        cfg_wr    = in_idle && cfg_we;
        last      = (idx == IW'(N_NEURONS - 1));
        case (state)
            IDLE:    if (tick) state_nxt = UPDATE;
            UPDATE:  if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Shift of 0 means "no leak", not "leak everything".
    always_comb begin
        v_cur      = v_mem[idx];
        r_cur      = r_mem[idx];
        leak_amt   = (cfg.leak == 3'd0) ? '0 : (v_cur >> cfg.leak);
        v_leak     = v_cur - leak_amt;
        sum_w      = {1'b0, v_leak} + (in_q[idx] ? (V_WIDTH+1)'(cfg.weight) : '0);
        sum_sat    = sum_w[V_WIDTH] ? '1 : sum_w[V_WIDTH-1:0];
        refractory = (r_cur != 4'd0);
        fire       = !refractory && (sum_sat >= V_WIDTH'(cfg.thresh));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg          <= CFG_RST;
            idx          <= '0;
            in_q         <= '0;
            acc          <= '0;
            spike_out    <= '0;
            step_done    <= 1'b0;
            busy         <= 1'b0;
            tick_overrun <= 1'b0;
            cfg_err      <= 1'b0;
            for (int i = 0; i < N_NEURONS; i++) begin
                v_mem[i] <= '0;
                r_mem[i] <= '0;
            end
        end else begin
            step_done <= 1'b0;

            if (tick && !in_idle)     tick_overrun <= 1'b1;
            else if (ovr_clr)         tick_overrun <= 1'b0;
            if (cfg_we && !in_idle)   cfg_err <= 1'b1;
            else if (ovr_clr)         cfg_err <= 1'b0;

            if (cfg_wr) begin
                case (cfg_addr)
                    2'd0:    cfg.thresh <= cfg_data;
                    2'd1:    cfg.weight <= cfg_data;
                    2'd2:    cfg.leak   <= cfg_data[2:0];
                    default: cfg.refrac <= cfg_data[3:0];
                endcase
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        in_q <= spike_in;
                        idx  <= '0;
                        acc  <= '0;
                        busy <= 1'b1;
                    end
                end
                UPDATE: begin
                    if (refractory) begin
                        r_mem[idx] <= r_cur - 4'd1;
                        v_mem[idx] <= '0;
                    end else if (fire) begin
                        r_mem[idx] <= cfg.refrac;
                        v_mem[idx] <= '0;
                        acc[idx]   <= 1'b1;
                    end else begin
                        v_mem[idx] <= sum_sat;
                    end
                    idx <= idx + 1'b1;
                end
                DONE: begin
                    spike_out <= acc;
                    step_done <= 1'b1;
                    busy      <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef LIF_SPIKE_COUNT_EN
    logic [7:0] cnt [N_NEURONS];
    logic       spike_now;

    assign spike_now = (state == UPDATE) && fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_NEURONS; i++) cnt[i] <= '0;
        end else if (ovr_clr) begin
            for (int i = 0; i < N_NEURONS; i++) cnt[i] <= '0;
        end else if (spike_now && cnt[idx] != 8'hFF) begin
            cnt[idx] <= cnt[idx] + 8'd1;
        end
    end

    assign rd_data = cnt[rd_sel];
`else
    logic unused_rd_sel;
    assign unused_rd_sel = ^rd_sel;
    assign rd_data       = '0;
`endif

endmodule

// File: tb/tb_lif_tdm_sched.sv
// Bench for lif_tdm_sched: sweep-level behavioural model checked every cycle, plus directed literal checks.
module tb_lif_tdm_sched;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         tick = 1'b0;
    logic [N-1:0] spike_in = '0;
    logic         cfg_we = 1'b0;
    logic [1:0]   cfg_addr = '0;
    logic [7:0]   cfg_data = '0;
    logic         ovr_clr = 1'b0;
    logic [1:0]   rd_sel = '0;
    logic [N-1:0] spike_out;
    logic         step_done, busy, tick_overrun, cfg_err;
    logic [7:0]   rd_data;

    lif_tdm_sched #(.N_NEURONS(N)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .spike_in(spike_in),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .ovr_clr(ovr_clr),
        .spike_out(spike_out), .step_done(step_done), .busy(busy),
        .tick_overrun(tick_overrun), .cfg_err(cfg_err), .rd_sel(rd_sel), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a whole sweep is evaluated at the accepting edge; results are released N+1 edges later.
    int           m_v [N];
    int           m_r [N];
    int           m_cnt [N];
    int           m_thr, m_w, m_ls, m_rf, m_e, m_done;
    bit           m_act, m_sd, m_busy, m_ovr, m_cerr, m_idle;
    logic [N-1:0] m_pend, m_spk;

    always @(posedge clk) begin
        bit idle;
        int s, lk;
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin m_v[i] = 0; m_r[i] = 0; m_cnt[i] = 0; end
            m_thr = 200; m_w = 40; m_ls = 3; m_rf = 2;
            m_e = 0; m_done = 0; m_act = 0; m_sd = 0; m_busy = 0; m_ovr = 0; m_cerr = 0;
            m_pend = '0; m_spk = '0;
        end else begin
            m_e++;
            idle = !m_act || (m_e > m_done);
            if (!idle && tick) m_ovr = 1; else if (ovr_clr) m_ovr = 0;
            if (!idle && cfg_we) m_cerr = 1; else if (ovr_clr) m_cerr = 0;
            if (ovr_clr) for (int i = 0; i < N; i++) m_cnt[i] = 0;
            if (idle && cfg_we) begin
                case (cfg_addr)
                    2'd0: m_thr = int'(cfg_data);
                    2'd1: m_w   = int'(cfg_data);
                    2'd2: m_ls  = int'(cfg_data) % 8;
                    default: m_rf = int'(cfg_data) % 16;
                endcase
            end
            if (idle && tick) begin
                for (int i = 0; i < N; i++) begin
                    if (m_r[i] > 0) begin
                        m_r[i]--; m_v[i] = 0; m_pend[i] = 1'b0;
                    end else begin
                        lk = (m_ls == 0) ? 0 : m_v[i] / (2 ** m_ls);
                        s  = m_v[i] - lk + (spike_in[i] ? m_w : 0);
                        if (s > 255) s = 255;
                        if (s >= m_thr) begin
                            m_pend[i] = 1'b1; m_v[i] = 0; m_r[i] = m_rf;
                            if (m_cnt[i] < 255) m_cnt[i]++;
                        end else begin
                            m_pend[i] = 1'b0; m_v[i] = s;
                        end
                    end
                end
                m_act  = 1;
                m_done = m_e + N + 1;
            end
            m_sd = m_act && (m_e == m_done);
            if (m_sd) m_spk = m_pend;
            m_busy = m_act && (m_e < m_done);
        end
        m_idle = !m_act || (m_e >= m_done);
    end

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            chk("spike_out", 32'(spike_out), 32'(m_spk));
            chk("step_done", 32'(step_done), 32'(m_sd));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("tick_overrun", 32'(tick_overrun), 32'(m_ovr));
            chk("cfg_err", 32'(cfg_err), 32'(m_cerr));
`ifdef LIF_SPIKE_COUNT_EN
            if (m_idle) chk("rd_data", 32'(rd_data), 32'(m_cnt[rd_sel]));
`else
            chk("rd_data", 32'(rd_data), 32'd0);
`endif
        end
    end

    task automatic tick_wait(input logic [N-1:0] s, input bit wr, input logic [1:0] a,
                             input logic [7:0] d, output logic [N-1:0] so, output int lat);
        @(negedge clk);
        tick = 1'b1; spike_in = s; cfg_we = wr; cfg_addr = a; cfg_data = d;
        @(negedge clk);
        tick = 1'b0; cfg_we = 1'b0;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (step_done) break;
        end
        so = spike_out;
    endtask

    task automatic cfg_wr(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] so;
        int lat, sd_cnt;

        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        chk("rst_spike_out", 32'(spike_out), 0);
        chk("rst_step_done", 32'(step_done), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_overrun", 32'(tick_overrun), 0);
        chk("rst_cfg_err", 32'(cfg_err), 0);
        @(negedge clk) rst_n = 1'b1;

        // No leak, weight 40, threshold 200: fires on ticks 5 and 12 (refractory 6,7).
        cfg_wr(2'd2, 8'd0);
        for (int t = 1; t <= 12; t++) begin
            tick_wait(4'b0001, 1'b0, 2'd0, 8'd0, so, lat);
            chk("A_latency", 32'(lat), N + 1);
            chk("A_spikes", 32'(so), (t == 5 || t == 12) ? 32'd1 : 32'd0);
        end

        // Defaults on neuron 1: 40,75,106,133,157,178,196 then fires at 212 on tick 8.
        do_reset();
        for (int t = 1; t <= 8; t++) begin
            tick_wait(4'b0010, 1'b0, 2'd0, 8'd0, so, lat);
            chk("B_spikes", 32'(so), (t == 8) ? 32'd2 : 32'd0);
        end

        // Saturation: 200 then 400 -> 255 reaches threshold 255.
        do_reset();
        cfg_wr(2'd2, 8'd0);
        cfg_wr(2'd1, 8'd200);
        cfg_wr(2'd0, 8'd255);
        tick_wait(4'b0001, 1'b0, 2'd0, 8'd0, so, lat);
        chk("C_tick1", 32'(so), 0);
        tick_wait(4'b0001, 1'b0, 2'd0, 8'd0, so, lat);
        chk("C_tick2", 32'(so), 1);

        // Tick and cfg write on the same idle edge: new threshold 30 used by this sweep.
        do_reset();
        tick_wait(4'b0001, 1'b1, 2'd0, 8'd30, so, lat);
        chk("D_same_edge", 32'(so), 1);

        // Overrun and cfg write while busy.
        do_reset();
        @(negedge clk) begin tick = 1'b1; spike_in = 4'b0001; end
        @(negedge clk) tick = 1'b0;
        @(negedge clk);
        @(negedge clk) tick = 1'b1;
        @(negedge clk) begin tick = 1'b0; cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 8'd5; end
        @(negedge clk) cfg_we = 1'b0;
        sd_cnt = 0;
        repeat (12) begin @(posedge clk); #1; if (step_done) sd_cnt++; end
        chk("E_done_count", 32'(sd_cnt), 1);
        chk("E_overrun", 32'(tick_overrun), 1);
        chk("E_cfg_err", 32'(cfg_err), 1);
        tick_wait(4'b0001, 1'b0, 2'd0, 8'd0, so, lat);
        chk("E_thresh_kept", 32'(so), 0);
        @(negedge clk) ovr_clr = 1'b1;
        @(negedge clk) ovr_clr = 1'b0;
        chk("E_clr_overrun", 32'(tick_overrun), 0);
        chk("E_clr_cfg_err", 32'(cfg_err), 0);

        // Reset during idx 2 of a sweep: no step_done, neuron 3 potential cleared.
        do_reset();
        for (int t = 1; t <= 7; t++) tick_wait(4'b1000, 1'b0, 2'd0, 8'd0, so, lat);
        @(negedge clk) begin tick = 1'b1; spike_in = 4'b1000; end
        @(negedge clk) tick = 1'b0;
        @(negedge clk);
        @(negedge clk) rst_n = 1'b0;
        sd_cnt = 0;
        repeat (8) begin @(posedge clk); #1; if (step_done) sd_cnt++; end
        chk("F_no_done", 32'(sd_cnt), 0);
        chk("F_busy", 32'(busy), 0);
        @(negedge clk) rst_n = 1'b1;
        tick_wait(4'b1000, 1'b0, 2'd0, 8'd0, so, lat);
        chk("F_v_cleared", 32'(so), 0);

        // Threshold 0, no refractory: every neuron fires every step.
        do_reset();
        cfg_wr(2'd0, 8'd0);
        cfg_wr(2'd3, 8'd0);
`ifdef LIF_SPIKE_COUNT_EN
        for (int t = 1; t <= 300; t++) tick_wait(4'b0001, 1'b0, 2'd0, 8'd0, so, lat);
        chk("G_all_fire", 32'(so), 15);
        @(negedge clk) rd_sel = 2'd0;
        #1 chk("G_count_sat", 32'(rd_data), 255);
        @(negedge clk) ovr_clr = 1'b1;
        @(negedge clk) ovr_clr = 1'b0;
        #1 chk("G_count_clr", 32'(rd_data), 0);
`else
        for (int t = 1; t <= 5; t++) tick_wait(4'b0001, 1'b0, 2'd0, 8'd0, so, lat);
        chk("G_all_fire", 32'(so), 15);
        @(negedge clk) rd_sel = 2'd1;
        #1 chk("G_rd_data_zero", 32'(rd_data), 0);
`endif
        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
